systolic_input_stager: RTL and testbench

// - Parametrised successor of the core input controller: buffers LANES-wide

---
 rtl/systolic_input_stager.sv | 131 +++++++++++++
 tb/tb_systolic_input_stager.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_input_stager.sv
// Lockstep A/W row FIFO feeding a diagonally skewed per-lane pipe for a systolic array edge.
// Define SYSTOLA_INP_ERR_EN to build the sticky overflow/underflow flags; otherwise ovf/udf are tied low.
module systolic_input_stager #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic [LANES-1:0][DW-1:0]  ainport,
  input  logic [LANES-1:0][DW-1:0]  winport,
  input  logic                      write,
  input  logic                      read,
  output logic                      full,
  output logic                      empty,
  output logic [CW-1:0]             count,
  output logic [LANES-1:0][DW-1:0]  as,
  output logic [LANES-1:0][DW-1:0]  ws,
  output logic [LANES-1:0]          avalid,
  output logic                      ovf,
  output logic                      udf
);

  localparam int PW = $clog2(DEPTH);

  logic [LANES-1:0][DW-1:0] a_mem [DEPTH];
  logic [LANES-1:0][DW-1:0] w_mem [DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            cnt;
  logic                     pop_acc, push_acc;
  logic [LANES-1:0][DW-1:0] head_a, head_w;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_acc  = read && !empty;
  assign push_acc = write && (!full || pop_acc);

  // Rows not popped this cycle enter the pipe as an invalid, zeroed row.
  assign head_a = pop_acc ? a_mem[rd_ptr] : '0;
  assign head_w = pop_acc ? w_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_acc && !clr) begin
      a_mem[wr_ptr] <= ainport;
      w_mem[wr_ptr] <= winport;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_acc, pop_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Lane g is registered through g+1 stages, producing the diagonal wavefront.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DW-1:0] a_pipe [0:g];
    logic [DW-1:0] w_pipe [0:g];
    logic          v_pipe [0:g];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int k = 0; k <= g; k++) begin
          a_pipe[k] <= '0;
          w_pipe[k] <= '0;
          v_pipe[k] <= 1'b0;
        end
      end else if (clr) begin
        for (int k = 0; k <= g; k++) begin
          a_pipe[k] <= '0;
          w_pipe[k] <= '0;
          v_pipe[k] <= 1'b0;
        end
      end else begin
        a_pipe[0] <= head_a[g];
        w_pipe[0] <= head_w[g];
        v_pipe[0] <= pop_acc;
        for (int k = 1; k <= g; k++) begin
          a_pipe[k] <= a_pipe[k-1];
          w_pipe[k] <= w_pipe[k-1];
          v_pipe[k] <= v_pipe[k-1];
        end
      end
    end

    assign as[g]     = a_pipe[g];
    assign ws[g]     = w_pipe[g];
    assign avalid[g] = v_pipe[g];
  end

`ifdef SYSTOLA_INP_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (write && full && !read) ovf_q <= 1'b1;
      if (read && empty)          udf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_input_stager.sv
// Directed bench for systolic_input_stager: row-queue scoreboard plus skew history model, checked every cycle.
module tb_systolic_input_stager;
  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0, rstn = 1'b0, clr = 1'b0, write = 1'b0, read = 1'b0;
  logic [LANES-1:0][DW-1:0] ainport = '0, winport = '0, as, ws;
  logic [LANES-1:0] avalid;
  logic full, empty, ovf, udf;
  logic [CW-1:0] count;

  int passed = 0, total = 0;

  typedef struct packed {
    logic [LANES-1:0][DW-1:0] a;
    logic [LANES-1:0][DW-1:0] w;
  } row_t;

  row_t sb[$];
  row_t hist [LANES];
  logic hv   [LANES];
  logic m_ovf, m_udf;

  systolic_input_stager #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .ainport(ainport), .winport(winport),
    .write(write), .read(read), .full(full), .empty(empty), .count(count),
    .as(as), .ws(ws), .avalid(avalid), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_model();
    sb.delete();
    for (int k = 0; k < LANES; k++) begin
      hist[k] = '0;
      hv[k]   = 1'b0;
    end
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic check_outputs(input string ph);
    for (int i = 0; i < LANES; i++) begin
      chk($sformatf("%s_as%0d", ph, i), 32'(as[i]), hv[i] ? 32'(hist[i].a[i]) : 32'd0);
      chk($sformatf("%s_ws%0d", ph, i), 32'(ws[i]), hv[i] ? 32'(hist[i].w[i]) : 32'd0);
      chk($sformatf("%s_avalid%0d", ph, i), 32'(avalid[i]), 32'(hv[i]));
    end
    chk({ph, "_count"}, 32'(count), 32'(sb.size()));
    chk({ph, "_full"},  32'(full),  32'(sb.size() == DEPTH));
    chk({ph, "_empty"}, 32'(empty), 32'(sb.size() == 0));
`ifdef SYSTOLA_INP_ERR_EN
    chk({ph, "_ovf"}, 32'(ovf), 32'(m_ovf));
    chk({ph, "_udf"}, 32'(udf), 32'(m_udf));
`else
    chk({ph, "_ovf"}, 32'(ovf), 32'd0);
    chk({ph, "_udf"}, 32'(udf), 32'd0);
`endif
  endtask

  // Advance one clock edge; the model uses the pre-edge state, outputs are sampled 1ns after the edge.
  task automatic tick(input string ph);
    bit pop, push;
    if (clr) begin
      clear_model();
    end else begin
      pop  = read && (sb.size() > 0);
      push = write && ((sb.size() < DEPTH) || pop);
      if (write && sb.size() == DEPTH && !read) m_ovf = 1'b1;
      if (read && sb.size() == 0) m_udf = 1'b1;
      for (int k = LANES - 1; k > 0; k--) begin
        hist[k] = hist[k-1];
        hv[k]   = hv[k-1];
      end
      if (pop) begin
        hist[0] = sb.pop_front();
        hv[0]   = 1'b1;
      end else begin
        hist[0] = '0;
        hv[0]   = 1'b0;
      end
      if (push) sb.push_back({ainport, winport});
    end
    @(posedge clk);
    #1;
    check_outputs(ph);
  endtask

  task automatic set_row(input int seed);
    for (int i = 0; i < LANES; i++) begin
      ainport[i] = DW'(seed * 16 + i + 1);
      winport[i] = DW'(8'h80 + seed * 8 + i);
    end
  endtask

  initial begin
    clear_model();
    // 1: reset state
    #7;
    check_outputs("rst");
    rstn = 1'b1;

    // 2: one row, read next cycle, watch the one-hot wavefront
    for (int i = 0; i < LANES; i++) begin
      ainport[i] = DW'(i + 1);
      winport[i] = DW'(8'h10 + i);
    end
    write = 1'b1; tick("t2_wr");
    write = 1'b0; read = 1'b1; tick("t2_rd");
    chk("t2_as0_direct", 32'(as[0]), 32'd1);
    chk("t2_ws0_direct", 32'(ws[0]), 32'h10);
    read = 1'b0;
    for (int c = 1; c < LANES; c++) tick("t2_skew");
    chk("t2_as7_direct", 32'(as[7]), 32'd8);
    chk("t2_ws7_direct", 32'(ws[7]), 32'h17);
    chk("t2_avalid_onehot", 32'(avalid), 32'h80);
    tick("t2_tail");

    // 3: fill, drop 5th push, drain in order
    write = 1'b1;
    for (int r = 1; r <= 4; r++) begin set_row(r); tick("t3_fill"); end
    chk("t3_full_direct", 32'(full), 32'd1);
    chk("t3_count_direct", 32'(count), 32'd4);
    set_row(5); tick("t3_drop");
    write = 1'b0; read = 1'b1;
    repeat (4) tick("t3_drain");
    read = 1'b0;
    repeat (LANES) tick("t3_flush");

    // 4: full with read+write, then empty with read+write
    write = 1'b1;
    for (int r = 6; r <= 9; r++) begin set_row(r); tick("t4_fill"); end
    read = 1'b1; set_row(10); tick("t4_fullrw");
    chk("t4_count_full_rw", 32'(count), 32'd4);
    write = 1'b0;
    repeat (4) tick("t4_drain");
    write = 1'b1; set_row(11); tick("t4_emptyrw");
    chk("t4_count_empty_rw", 32'(count), 32'd1);
    write = 1'b0;
    tick("t4_last");
    read = 1'b0;
    repeat (LANES) tick("t4_flush");

    // 5: underflow then clr
    read = 1'b1; tick("t5_udf");
    read = 1'b0; tick("t5_hold");
    clr = 1'b1; tick("t5_clr");
    clr = 1'b0; tick("t5_post");

    // randomised traffic
    for (int c = 0; c < 60; c++) begin
      write = 1'($urandom_range(0, 1));
      read  = 1'($urandom_range(0, 1));
      for (int i = 0; i < LANES; i++) begin
        ainport[i] = DW'($urandom);
        winport[i] = DW'($urandom);
      end
      tick("rnd");
    end

    // 6a: async reset mid-stream
    write = 1'b1; read = 1'b1;
    repeat (3) tick("t6_stream");
    write = 1'b0; read = 1'b0;
    #3;
    rstn = 1'b0;
    clear_model();
    #1;
    check_outputs("t6_async_rst");
    rstn = 1'b1;
    @(posedge clk); #1;

    // 6b: clr mid-stream with concurrent write/read
    write = 1'b1; set_row(12); tick("t6_push1");
    set_row(13); tick("t6_push2");
    read = 1'b1; set_row(14); tick("t6_rw");
    clr = 1'b1; tick("t6_clr");
    chk("t6_avalid_after_clr", 32'(avalid), 32'd0);
    chk("t6_count_after_clr", 32'(count), 32'd0);
    clr = 1'b0; write = 1'b0; read = 1'b0;
    tick("t6_post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
